buf_arb_mon: RTL and testbench

Parametrised successor to the two-level buffer monitor: arbitrates N_CH transmit-side queues onto the single TX datapath select and drives the upstream `tx_pause`. It adds several behaviours the current monitor lacks: registered grants, per-grant burst limit, age-based starvation override, hysteretic pause on one monitored queue, and stretched per-queue reset pulses after reset release. It sits between the queue FIFOs (mem/req/net) and the TX mux / `axis_xgmii_tx` ready path.

---
 rtl/buf_pkg.sv | 24 ++
 rtl/buf_age_ctr.sv | 37 +++
 rtl/buf_arb_mon.sv | 175 +++++++++++++++++
 tb/tb_buf_arb_mon.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_pkg.sv
// Shared types and constants for the buffer arbiter/monitor and its age counters.
package buf_pkg;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_IDLE     = 2'd1,
        ST_GRANT    = 2'd2
    } arb_state_t;

    localparam int SEL_IDLE      = 0;
    localparam int DEF_BURST     = 4;
    localparam int DEF_PAUSE_ON  = 16;
    localparam int DEF_PAUSE_OFF = 24;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/buf_age_ctr.sv
// Per-queue waiting-time counter: counts cycles a queue sits non-empty without being read.
module buf_age_ctr
    import buf_pkg::*;
#(
    parameter int MAX_WAIT = 32,
    parameter int AGE_W    = clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             non_empty,
    input  logic             rd,
    output logic [AGE_W-1:0] age,
    output logic             starved
);

    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;

    always_comb begin
        age_d = '0;
        if (non_empty && !rd) begin
            age_d = (age_q == AGE_W'(MAX_WAIT)) ? age_q : age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age     = age_q;
    assign starved = (age_q == AGE_W'(MAX_WAIT));

endmodule

// File: rtl/buf_arb_mon.sv
// Arbitrates N_CH transmit queues onto one TX select with burst limit, starvation
// override, hysteretic upstream pause and stretched per-queue reset after reset release.
module buf_arb_mon
    import buf_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int SPACE_W     = 6,
    parameter int BURST       = DEF_BURST,
    parameter int MAX_WAIT    = 32,
    parameter int PAUSE_CH    = 2,
    parameter int PAUSE_ON    = DEF_PAUSE_ON,
    parameter int PAUSE_OFF   = DEF_PAUSE_OFF,
    parameter int QRST_CYCLES = 2,
    localparam int SEL_W      = clog2(N_CH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         q_empty,
    input  logic [N_CH*SPACE_W-1:0] q_space,
    output logic [N_CH-1:0]         q_read,
    output logic [N_CH-1:0]         q_reset,
    output logic [SEL_W-1:0]        sel,
    output logic                    tx_pause
);

    localparam int IDX_W  = (N_CH > 1) ? clog2(N_CH) : 1;
    localparam int BCNT_W = (BURST > 1) ? clog2(BURST) : 1;
    localparam int RCNT_W = (QRST_CYCLES > 1) ? clog2(QRST_CYCLES) : 1;
    localparam int AGE_W  = clog2(MAX_WAIT + 1);

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        cur_q, cur_d;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [RCNT_W-1:0]       rcnt_q, rcnt_d;
    logic [N_CH-1:0]         q_reset_q, q_reset_d;
    logic                    pause_q, pause_d;

    logic [N_CH-1:0]             starved;
    logic [N_CH-1:0][AGE_W-1:0]  ages;
    logic [N_CH-1:0]             cur_mask;
    logic [IDX_W:0]              win_all;
    logic [IDX_W:0]              win_oth;
    logic [SPACE_W-1:0]          pause_space;
    logic                        burst_done;
    logic                        unused_inputs;

    // MSB flags a valid winner; starved queues beat plain priority.
    function automatic logic [IDX_W:0] pick_winner(input logic [N_CH-1:0] avail,
                                                   input logic [N_CH-1:0] old);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (avail[i]) res = {1'b1, IDX_W'(i)};
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (avail[i] && old[i]) res = {1'b1, IDX_W'(i)};
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_age
        buf_age_ctr #(
            .MAX_WAIT (MAX_WAIT),
            .AGE_W    (AGE_W)
        ) u_age (
            .clk       (clk),
            .reset     (reset),
            .non_empty (!q_empty[gi]),
            .rd        (q_read[gi]),
            .age       (ages[gi]),
            .starved   (starved[gi])
        );
    end

    always_comb begin
        q_read = '0;
        if (state_q == ST_GRANT && !q_empty[cur_q]) begin
            q_read[cur_q] = 1'b1;
        end
    end

    assign pause_space   = q_space[PAUSE_CH*SPACE_W +: SPACE_W];
    assign unused_inputs = ^{q_space, ages};

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        bcnt_d    = bcnt_q;
        sel_d     = sel_q;
        rcnt_d    = rcnt_q;
        q_reset_d = q_reset_q;
        pause_d   = pause_q;

        cur_mask        = '0;
        cur_mask[cur_q] = 1'b1;
        win_all    = pick_winner(~q_empty, starved);
        win_oth    = pick_winner(~q_empty & ~cur_mask, starved);
        burst_done = q_empty[cur_q] || (bcnt_q == BCNT_W'(BURST - 1));

        case (state_q)
            ST_RST_HOLD: begin
                sel_d = SEL_W'(SEL_IDLE);
                if (rcnt_q == RCNT_W'(QRST_CYCLES - 1)) begin
                    q_reset_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                end
            end
            ST_IDLE: begin
                sel_d = SEL_W'(SEL_IDLE);
                if (win_all[IDX_W]) begin
                    cur_d   = win_all[IDX_W-1:0];
                    bcnt_d  = '0;
                    sel_d   = SEL_W'(win_all[IDX_W-1:0]) + SEL_W'(1);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (burst_done) begin
                    // Hand over in the same cycle so back-to-back grants leave no gap.
                    if (win_oth[IDX_W]) begin
                        cur_d  = win_oth[IDX_W-1:0];
                        bcnt_d = '0;
                        sel_d  = SEL_W'(win_oth[IDX_W-1:0]) + SEL_W'(1);
                    end else if (!q_empty[cur_q]) begin
                        bcnt_d = '0;
                    end else begin
                        bcnt_d  = '0;
                        sel_d   = SEL_W'(SEL_IDLE);
                        state_d = ST_IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
                sel_d   = SEL_W'(SEL_IDLE);
            end
        endcase

        if (pause_space < SPACE_W'(PAUSE_ON)) begin
            pause_d = 1'b1;
        end else if (pause_space >= SPACE_W'(PAUSE_OFF)) begin
            pause_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RST_HOLD;
            cur_q     <= '0;
            bcnt_q    <= '0;
            sel_q     <= SEL_W'(SEL_IDLE);
            rcnt_q    <= '0;
            q_reset_q <= '1;
            pause_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            bcnt_q    <= bcnt_d;
            sel_q     <= sel_d;
            rcnt_q    <= rcnt_d;
            q_reset_q <= q_reset_d;
            pause_q   <= pause_d;
        end
    end

    assign sel      = sel_q;
    assign q_reset  = q_reset_q;
    assign tx_pause = pause_q;

endmodule

// File: tb/tb_buf_arb_mon.sv
// Self-checking bench for buf_arb_mon: directed sequences, a pause vector table and
// randomized traffic compared against a cycle-level behavioural model.
module tb_buf_arb_mon;

    localparam int N     = 3;
    localparam int SW    = 6;
    localparam int BURST = 4;
    localparam int MAXW  = 32;
    localparam int PCH   = 2;
    localparam int PON   = 16;
    localparam int POFF  = 24;
    localparam int QRST  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    q_empty;
    logic [N*SW-1:0] q_space;
    logic [N-1:0]    q_read;
    logic [N-1:0]    q_reset;
    logic [1:0]      sel;
    logic            tx_pause;

    logic [4:0]      q_empty5;
    logic [5*SW-1:0] q_space5;
    logic [4:0]      q_read5;
    logic [4:0]      q_reset5;
    logic [2:0]      sel5;
    logic            tx_pause5;

    always #5 clk = ~clk;

    buf_arb_mon u_dut (
        .clk      (clk),
        .reset    (reset),
        .q_empty  (q_empty),
        .q_space  (q_space),
        .q_read   (q_read),
        .q_reset  (q_reset),
        .sel      (sel),
        .tx_pause (tx_pause)
    );

    buf_arb_mon #(.N_CH(5), .BURST(1)) u_dut5 (
        .clk      (clk),
        .reset    (reset),
        .q_empty  (q_empty5),
        .q_space  (q_space5),
        .q_read   (q_read5),
        .q_reset  (q_reset5),
        .sel      (sel5),
        .tx_pause (tx_pause5)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: 0 = reset hold, 1 = idle, 2 = granting
    int          m_state;
    int          m_hold;
    int          m_cur;
    int          m_bcnt;
    int          m_sel;
    int          m_age [N];
    logic [N-1:0] m_qrst;
    logic        m_pause;

    bit use_cnt = 1'b0;
    int cnt [N];

    typedef struct {
        logic [SW-1:0] space;
        logic          exp_pause;
    } pause_vec_t;

    pause_vec_t pv [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_hold  = QRST;
        m_cur   = 0;
        m_bcnt  = 0;
        m_sel   = 0;
        m_qrst  = '1;
        m_pause = 1'b0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
    endtask

    function automatic logic [N-1:0] exp_read();
        logic [N-1:0] r;
        r = '0;
        if (m_state == 2 && !q_empty[m_cur]) r[m_cur] = 1'b1;
        return r;
    endfunction

    function automatic int m_pick(input logic [N-1:0] avail);
        for (int i = 0; i < N; i++) begin
            if (avail[i] && m_age[i] >= MAXW) return i;
        end
        for (int i = 0; i < N; i++) begin
            if (avail[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_next();
        logic [N-1:0] rd;
        logic [N-1:0] avail;
        logic [N-1:0] oth;
        int w;
        int sp;
        int nage [N];
        rd    = exp_read();
        avail = ~q_empty;
        for (int i = 0; i < N; i++) begin
            if (avail[i] && !rd[i]) nage[i] = (m_age[i] < MAXW) ? m_age[i] + 1 : MAXW;
            else nage[i] = 0;
        end
        case (m_state)
            0: begin
                m_hold--;
                if (m_hold == 0) begin
                    m_state = 1;
                    m_qrst  = '0;
                end
            end
            1: begin
                w = m_pick(avail);
                if (w >= 0) begin
                    m_state = 2;
                    m_cur   = w;
                    m_bcnt  = 0;
                    m_sel   = w + 1;
                end
            end
            default: begin
                if (q_empty[m_cur] || (rd[m_cur] && m_bcnt == BURST - 1)) begin
                    oth        = avail;
                    oth[m_cur] = 1'b0;
                    w          = m_pick(oth);
                    if (w >= 0) begin
                        m_cur  = w;
                        m_bcnt = 0;
                        m_sel  = w + 1;
                    end else if (avail[m_cur]) begin
                        m_bcnt = 0;
                    end else begin
                        m_state = 1;
                        m_sel   = 0;
                        m_bcnt  = 0;
                    end
                end else begin
                    m_bcnt++;
                end
            end
        endcase
        sp = int'(q_space[PCH*SW +: SW]);
        if (sp < PON) m_pause = 1'b1;
        else if (sp >= POFF) m_pause = 1'b0;
        for (int i = 0; i < N; i++) m_age[i] = nage[i];
    endtask

    // One clock: check outputs against the model, advance the model, move to next negedge.
    task automatic do_cycle();
        logic [N-1:0] er;
        #1;
        er = exp_read();
        check("q_read", q_read, er);
        check("sel", sel, m_sel);
        check("q_reset", q_reset, m_qrst);
        check("tx_pause", tx_pause, m_pause);
        check("read_onehot", $countones(q_read) <= 1, 1);
        if (reset) model_next();
        if (use_cnt) begin
            for (int i = 0; i < N; i++) begin
                if (er[i] && cnt[i] > 0) cnt[i]--;
            end
        end
        @(negedge clk);
        if (use_cnt) begin
            for (int i = 0; i < N; i++) q_empty[i] = (cnt[i] == 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_list [$];
        int s2_exp [13];
        int sel_hist [20];
        int idx;
        int first;
        int last;
        int gaps;
        int n;
        logic [N-1:0] exp_qrst [4];

        s2_exp = '{0, 0, 0, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0};
        exp_qrst = '{3'b111, 3'b111, 3'b000, 3'b000};
        pv[0]  = '{6'd20, 1'b0};
        pv[1]  = '{6'd15, 1'b1};
        pv[2]  = '{6'd20, 1'b1};
        pv[3]  = '{6'd24, 1'b0};
        pv[4]  = '{6'd10, 1'b1};
        pv[5]  = '{6'd16, 1'b1};
        pv[6]  = '{6'd23, 1'b1};
        pv[7]  = '{6'd24, 1'b0};
        pv[8]  = '{6'd16, 1'b0};
        pv[9]  = '{6'd15, 1'b1};
        pv[10] = '{6'd0,  1'b1};
        pv[11] = '{6'd63, 1'b0};

        reset    = 1'b0;
        q_empty  = '1;
        q_space  = {N{6'd30}};
        q_empty5 = '1;
        q_space5 = {5{6'd30}};
        model_reset();
        @(negedge clk);
        do_cycle();
        do_cycle();

        // Reset release with all queues empty
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("release_q_reset", q_reset, exp_qrst[k]);
            check("release_sel", sel, 0);
            do_cycle();
        end
        $display("reset release sequence done");

        // Queue 0 holds 10 entries, queue 2 holds 3
        use_cnt = 1'b1;
        cnt[0] = 10; cnt[1] = 0; cnt[2] = 3;
        for (int i = 0; i < N; i++) q_empty[i] = (cnt[i] == 0);
        first = -1; last = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            sel_hist[c] = int'(sel);
            idx = onehot_idx({2'b00, q_read});
            if (idx >= 0) begin
                rd_list.push_back(idx);
                if (first < 0) first = c;
                last = c;
                $display("cycle %0d read q%0d sel=%0d", c, idx, sel);
            end
            do_cycle();
        end
        gaps = 0;
        if (first >= 0) begin
            for (int c = first; c <= last; c++) if (sel_hist[c] == 0) gaps++;
        end
        check("fifo_sel_gaps", gaps, 0);
        check("fifo_read_count", rd_list.size(), 13);
        for (int k = 0; k < 13; k++) begin
            check("fifo_read_order", (k < rd_list.size()) ? rd_list[k] : -1, s2_exp[k]);
        end
        use_cnt = 1'b0;
        q_empty = '1;
        do_cycle();
        do_cycle();

        // Pause hysteresis table
        for (int v = 0; v < 12; v++) begin
            q_space[PCH*SW +: SW] = pv[v].space;
            do_cycle();
            #1;
            $display("pause vector %0d space=%0d tx_pause=%0d", v, pv[v].space, tx_pause);
            check("pause_table", tx_pause, pv[v].exp_pause);
        end
        q_space[PCH*SW +: SW] = 6'd30;
        do_cycle();
        do_cycle();

        // q0 always full, q1 non-empty: q1 must get a grant
        q_empty = 3'b100;
        n = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (q_read[1] && n < 0) n = c;
            do_cycle();
        end
        $display("q1 first read after %0d cycles", n);
        check("q1_granted", (n >= 0) && (n <= MAXW + BURST), 1);

        // q0 and q1 always full, q2 only wins through the age override
        q_empty = 3'b000;
        n = -1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (q_read[2] && n < 0) n = c;
            do_cycle();
        end
        $display("q2 first read after %0d cycles", n);
        check("q2_age_override", (n >= MAXW) && (n <= MAXW + BURST + 1), 1);
        q_empty = '1;
        for (int c = 0; c < 3; c++) do_cycle();

        // Reset in the middle of a burst on q1
        q_empty = 3'b001;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (q_read[1]) n++;
            if (n == 3) break;
            do_cycle();
        end
        check("midburst_reached", n, 3);
        reset = 1'b0;
        model_reset();
        #1;
        check("midburst_q_read", q_read, 0);
        check("midburst_sel", sel, 0);
        check("midburst_q_reset", q_reset, 3'b111);
        do_cycle();
        do_cycle();
        reset = 1'b1;
        rd_list.delete();
        first = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            idx = onehot_idx({2'b00, q_read});
            if (idx >= 0) begin
                rd_list.push_back(idx);
                if (first < 0) first = c;
            end
            do_cycle();
        end
        $display("post-reset first read at cycle %0d", first);
        check("post_reset_first_read", first, QRST + 1);
        for (int k = 0; k < 5; k++) begin
            check("post_reset_order", (k < rd_list.size()) ? rd_list[k] : -1, (k < 4) ? 1 : 2);
        end
        q_empty = '1;
        do_cycle();

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) q_empty[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) q_space[PCH*SW +: SW] = SW'($urandom_range(0, 63));
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                model_reset();
                do_cycle();
                reset = 1'b1;
            end
            do_cycle();
        end
        $display("random phase done");
        q_empty = '1;
        for (int c = 0; c < 5; c++) do_cycle();

        // 5-queue, BURST=1 build: two busy queues alternate one read each
        q_empty5 = 5'b10101;
        rd_list.delete();
        gaps = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            idx = onehot_idx(q_read5);
            check("dut5_onehot", $countones(q_read5) <= 1, 1);
            if (idx >= 0) begin
                check("dut5_sel", sel5, idx + 1);
                rd_list.push_back(idx);
            end else if (rd_list.size() > 0) begin
                gaps++;
            end
            @(negedge clk);
        end
        $display("dut5 alternation reads=%0d", rd_list.size());
        check("dut5_gaps", gaps, 0);
        check("dut5_count", rd_list.size(), 13);
        for (int k = 0; k < rd_list.size(); k++) begin
            check("dut5_alternate", rd_list[k], (k % 2 == 0) ? 1 : 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
